// File: rtl/bcd_field_editor.sv
// Signed-BCD entry editor: cursor-driven digit editing (wrap or carry/saturate),
// scrolling display window, cursor blink, parallel load and overflow pulse.
//
// Blink phase:
//   state      | meaning
//   PH_VISIBLE | cursor slot shows its normal code
//   PH_HIDDEN  | cursor slot is blanked (code 31)
module bcd_field_editor #(
    parameter int DIGITS    = 4,
    parameter int WIN       = 4,
    parameter int MODE      = 0,
    parameter int BLINK_DIV = 12500000,
    localparam int CW = $clog2(DIGITS + 2),
    localparam int VW = 4 * DIGITS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [VW-1:0]    load_val_i,
    input  logic             load_neg_i,
    output logic [VW-1:0]    value_o,
    output logic             sign_o,
    output logic [CW-1:0]    curr_o,
    output logic [CW-1:0]    win_base_o,
    output logic [5*WIN-1:0] disp_o,
    output logic             dirty_o,
    output logic             ovf_o
);

    typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_t;

    localparam int              BW         = $clog2(BLINK_DIV);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [CW-1:0]   POS_SIGN   = CW'(DIGITS);
    localparam logic [CW-1:0]   BASE_MAX   = CW'(DIGITS + 1 - WIN);
    localparam logic [4:0]      CODE_MINUS = 5'd26;
    localparam logic [4:0]      CODE_BLANK = 5'd31;

    logic [VW-1:0]    value_q, value_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    curr_q, curr_d;
    logic [CW-1:0]    base_q, base_d;
    logic             dirty_q, dirty_d;
    logic             ovf_q, ovf_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    phase_t           phase_q, phase_d;
    logic [5*WIN-1:0] disp_q, disp_d;
    logic             restart;

    logic [VW-1:0]    wrap_inc_v, wrap_dec_v, carry_inc_v, borrow_dec_v;
    logic             carry_out, borrow_out;
    logic [3:0]       nib;
    logic [4:0]       sum;
    logic [VW-1:0]    edit_v;
    logic             edit_sat;

    // Keep the cursor inside the visible window after a move.
    function automatic logic [CW-1:0] follow(input logic [CW-1:0] c, input logic [CW-1:0] b);
        logic [CW:0] top;
        top = {1'b0, b} + (CW+1)'(WIN - 1);
        if ({1'b0, c} > top)
            follow = CW'(c - CW'(WIN - 1));
        else if (c < b)
            follow = c;
        else
            follow = b;
    endfunction

    // Slot codes for a given editor state; slot 0 shows position b.
    function automatic logic [5*WIN-1:0] build_disp(input logic [VW-1:0] v, input logic s,
                                                     input logic [CW-1:0] c, input logic [CW-1:0] b,
                                                     input logic hide);
        logic [5*WIN-1:0] d;
        logic [CW:0]      p;
        d = '0;
        for (int i = 0; i < WIN; i++) begin
            p = {1'b0, b} + (CW+1)'(i);
            if (hide && (p == {1'b0, c}))
                d[5*i +: 5] = CODE_BLANK;
            else if (p < (CW+1)'(DIGITS))
                d[5*i +: 5] = {1'b0, 4'(v >> (4 * p))};
            else if (p == (CW+1)'(DIGITS))
                d[5*i +: 5] = s ? CODE_MINUS : CODE_BLANK;
            else
                d[5*i +: 5] = CODE_BLANK;
        end
        return d;
    endfunction

    // Candidate edit results at the cursor: per-digit wrap and full carry/borrow chain.
    always_comb begin
        wrap_inc_v   = value_q;
        wrap_dec_v   = value_q;
        carry_inc_v  = value_q;
        borrow_dec_v = value_q;
        carry_out    = 1'b1;
        borrow_out   = 1'b1;
        nib          = '0;
        sum          = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = value_q[4*i +: 4];
            if (CW'(i) == curr_q) begin
                wrap_inc_v[4*i +: 4] = (nib >= 4'd9) ? 4'd0 : nib + 4'd1;
                wrap_dec_v[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
            end
            if (CW'(i) >= curr_q) begin
                sum = {1'b0, nib} + {4'b0, carry_out};
                if (sum > 5'd9) begin
                    carry_inc_v[4*i +: 4] = 4'(sum - 5'd10);
                    carry_out             = 1'b1;
                end else begin
                    carry_inc_v[4*i +: 4] = sum[3:0];
                    carry_out             = 1'b0;
                end
                if (borrow_out && (nib == 4'd0)) begin
                    borrow_dec_v[4*i +: 4] = 4'd9;
                end else begin
                    borrow_dec_v[4*i +: 4] = nib - {3'b0, borrow_out};
                    borrow_out             = 1'b0;
                end
            end
        end
    end

    // One prioritised action per cycle: clr > load > left > right > inc > dec.
    always_comb begin
        value_d  = value_q;
        sign_d   = sign_q;
        curr_d   = curr_q;
        base_d   = base_q;
        dirty_d  = dirty_q;
        ovf_d    = 1'b0;
        restart  = 1'b0;
        edit_v   = inc_i ? wrap_inc_v : wrap_dec_v;
        edit_sat = 1'b0;
        if (MODE != 0) begin
            edit_v   = inc_i ? carry_inc_v : borrow_dec_v;
            edit_sat = inc_i ? carry_out : borrow_out;
        end
        if (clr_i) begin
            value_d = '0;
            sign_d  = 1'b0;
            curr_d  = '0;
            base_d  = '0;
            dirty_d = 1'b0;
        end else if (load_i) begin
            value_d = load_val_i;
            sign_d  = load_neg_i & (load_val_i != '0);
            curr_d  = '0;
            base_d  = '0;
            dirty_d = 1'b0;
        end else if (left_i) begin
            restart = 1'b1;
            if (curr_q == POS_SIGN) begin
                curr_d = '0;
                base_d = '0;
            end else begin
                curr_d = curr_q + 1'b1;
                base_d = follow(curr_q + 1'b1, base_q);
            end
        end else if (right_i) begin
            restart = 1'b1;
            if (curr_q == '0) begin
                curr_d = POS_SIGN;
                base_d = follow(POS_SIGN, BASE_MAX);
            end else begin
                curr_d = curr_q - 1'b1;
                base_d = follow(curr_q - 1'b1, base_q);
            end
        end else if (inc_i || dec_i) begin
            if (curr_q == POS_SIGN) begin
                // A zero magnitude cannot carry a sign, so the toggle is a no-op.
                if (value_q != '0) begin
                    sign_d  = ~sign_q;
                    dirty_d = 1'b1;
                    restart = 1'b1;
                end
            end else if (edit_sat) begin
                ovf_d = 1'b1;
            end else begin
                value_d = edit_v;
                sign_d  = sign_q & (edit_v != '0);
                dirty_d = 1'b1;
                restart = 1'b1;
            end
        end
    end

    // Blink timer: down the phase every BLINK_DIV clocks, restart on user activity.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = PH_VISIBLE;
        end else if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
        end
    end

    // Display codes lag the editor registers by one cycle.
    always_comb begin
        disp_d = build_disp(value_q, sign_q, curr_q, base_q, phase_q == PH_HIDDEN);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_q <= '0;
            sign_q  <= 1'b0;
            curr_q  <= '0;
            base_q  <= '0;
            dirty_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= PH_VISIBLE;
            disp_q  <= build_disp('0, 1'b0, '0, '0, 1'b0);
        end else begin
            value_q <= value_d;
            sign_q  <= sign_d;
            curr_q  <= curr_d;
            base_q  <= base_d;
            dirty_q <= dirty_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            disp_q  <= disp_d;
        end
    end

    assign value_o    = value_q;
    assign sign_o     = sign_q;
    assign curr_o     = curr_q;
    assign win_base_o = base_q;
    assign disp_o     = disp_q;
    assign dirty_o    = dirty_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_bcd_field_editor.sv
// Bench for bcd_field_editor: a wrap-mode (WIN 4) and a carry-mode (WIN 5) instance
// share one stimulus stream and are checked against an arithmetic reference model,
// a table of hand-computed vectors and a few hand-written blink/reset sequences.
module tb_bcd_field_editor;

    localparam logic [5:0] OP_NONE  = 6'b000000;
    localparam logic [5:0] OP_CLR   = 6'b100000;
    localparam logic [5:0] OP_LOAD  = 6'b010000;
    localparam logic [5:0] OP_LEFT  = 6'b001000;
    localparam logic [5:0] OP_RIGHT = 6'b000100;
    localparam logic [5:0] OP_INC   = 6'b000010;
    localparam logic [5:0] OP_DEC   = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        left = 1'b0, right = 1'b0, inc = 1'b0, dec = 1'b0, clr = 1'b0, load = 1'b0;
    logic [15:0] lv = '0;
    logic        ln = 1'b0;

    logic [15:0] value0, value1;
    logic        sign0, sign1, dirty0, dirty1, ovf0, ovf1;
    logic [2:0]  curr0, curr1, base0, base1;
    logic [19:0] disp0;
    logic [24:0] disp1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_field_editor #(.DIGITS(4), .WIN(4), .MODE(0), .BLINK_DIV(4)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .left_i(left), .right_i(right), .inc_i(inc), .dec_i(dec),
        .clr_i(clr), .load_i(load), .load_val_i(lv), .load_neg_i(ln),
        .value_o(value0), .sign_o(sign0), .curr_o(curr0), .win_base_o(base0),
        .disp_o(disp0), .dirty_o(dirty0), .ovf_o(ovf0));

    bcd_field_editor #(.DIGITS(4), .WIN(5), .MODE(1), .BLINK_DIV(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .left_i(left), .right_i(right), .inc_i(inc), .dec_i(dec),
        .clr_i(clr), .load_i(load), .load_val_i(lv), .load_neg_i(ln),
        .value_o(value1), .sign_o(sign1), .curr_o(curr1), .win_base_o(base1),
        .disp_o(disp1), .dirty_o(dirty1), .ovf_o(ovf1));

    // Reference model state, index 0 = wrap/WIN4, 1 = carry/WIN5. Magnitude kept as an integer.
    int          win_of [2] = '{4, 5};
    int          mode_of[2] = '{0, 1};
    int          m_mag[2], m_sign[2], m_cur[2], m_base[2], m_dirty[2], m_ovf[2], m_cnt[2], m_hide[2];
    logic [31:0] m_disp[2];

    function automatic int pow10(input int n);
        int r = 1;
        for (int j = 0; j < n; j++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int m);
        logic [15:0] r = '0;
        for (int j = 0; j < 4; j++) r[4*j +: 4] = 4'((m / pow10(j)) % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int r = 0;
        for (int j = 0; j < 4; j++) r = r + int'(b[4*j +: 4]) * pow10(j);
        return r;
    endfunction

    function automatic int mfollow(input int c, input int b, input int w);
        if (c > b + w - 1) return c - w + 1;
        if (c < b) return c;
        return b;
    endfunction

    function automatic logic [31:0] mdisp(input int k);
        logic [31:0] r = '0;
        int p;
        for (int i = 0; i < win_of[k]; i++) begin
            p = m_base[k] + i;
            if (m_hide[k] != 0 && p == m_cur[k]) r[5*i +: 5] = 5'd31;
            else if (p < 4) r[5*i +: 5] = 5'((m_mag[k] / pow10(p)) % 10);
            else r[5*i +: 5] = (m_sign[k] != 0) ? 5'd26 : 5'd31;
        end
        return r;
    endfunction

    task automatic model_step(input int k);
        int p, d, nd, nm;
        bit restart, ok;
        logic [31:0] nxt;
        if (!rst_n) begin
            m_mag[k] = 0; m_sign[k] = 0; m_cur[k] = 0; m_base[k] = 0;
            m_dirty[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_hide[k] = 0;
            m_disp[k] = mdisp(k);
        end else begin
            nxt = mdisp(k);
            restart = 0;
            m_ovf[k] = 0;
            if (clr) begin
                m_mag[k] = 0; m_sign[k] = 0; m_cur[k] = 0; m_base[k] = 0; m_dirty[k] = 0;
            end else if (load) begin
                m_mag[k] = from_bcd(lv);
                m_sign[k] = (ln && m_mag[k] != 0) ? 1 : 0;
                m_cur[k] = 0; m_base[k] = 0; m_dirty[k] = 0;
            end else if (left) begin
                restart = 1;
                if (m_cur[k] == 4) begin m_cur[k] = 0; m_base[k] = 0; end
                else begin m_cur[k]++; m_base[k] = mfollow(m_cur[k], m_base[k], win_of[k]); end
            end else if (right) begin
                restart = 1;
                if (m_cur[k] == 0) begin m_cur[k] = 4; m_base[k] = mfollow(4, 5 - win_of[k], win_of[k]); end
                else begin m_cur[k]--; m_base[k] = mfollow(m_cur[k], m_base[k], win_of[k]); end
            end else if (inc || dec) begin
                if (m_cur[k] == 4) begin
                    if (m_mag[k] != 0) begin
                        m_sign[k] = 1 - m_sign[k]; m_dirty[k] = 1; restart = 1;
                    end
                end else begin
                    p = pow10(m_cur[k]);
                    ok = 1;
                    if (mode_of[k] == 0) begin
                        d  = (m_mag[k] / p) % 10;
                        nd = inc ? (d + 1) % 10 : (d + 9) % 10;
                        nm = m_mag[k] + (nd - d) * p;
                    end else begin
                        nm = inc ? m_mag[k] + p : m_mag[k] - p;
                        if (nm > 9999 || nm < 0) begin ok = 0; m_ovf[k] = 1; end
                    end
                    if (ok) begin
                        m_mag[k] = nm;
                        if (nm == 0) m_sign[k] = 0;
                        m_dirty[k] = 1; restart = 1;
                    end
                end
            end
            if (restart) begin m_cnt[k] = 0; m_hide[k] = 0; end
            else if (m_cnt[k] == 3) begin m_cnt[k] = 0; m_hide[k] = 1 - m_hide[k]; end
            else m_cnt[k]++;
            m_disp[k] = nxt;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int k, input logic [15:0] v, input logic s, input logic [2:0] c,
                           input logic [2:0] b, input logic [31:0] dsp, input logic dt, input logic o);
        chk($sformatf("m%0d_value", k), 32'(v), 32'(to_bcd(m_mag[k])));
        chk($sformatf("m%0d_sign", k), 32'(s), 32'(m_sign[k]));
        chk($sformatf("m%0d_curr", k), 32'(c), 32'(m_cur[k]));
        chk($sformatf("m%0d_win_base", k), 32'(b), 32'(m_base[k]));
        chk($sformatf("m%0d_disp", k), dsp, m_disp[k]);
        chk($sformatf("m%0d_dirty", k), 32'(dt), 32'(m_dirty[k]));
        chk($sformatf("m%0d_ovf", k), 32'(o), 32'(m_ovf[k]));
    endtask

    // Apply one cycle of stimulus, advance the model on the same edge, compare #1 later.
    task automatic cycle(input logic [5:0] ops, input logic [15:0] val, input logic neg, input logic rn);
        {clr, load, left, right, inc, dec} = ops;
        lv = val; ln = neg; rst_n = rn;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp_dut(0, value0, sign0, curr0, base0, {12'b0, disp0}, dirty0, ovf0);
        cmp_dut(1, value1, sign1, curr1, base1, {7'b0, disp1}, dirty1, ovf1);
        {clr, load, left, right, inc, dec} = OP_NONE;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [5:0]  ops;
        logic [15:0] lv;
        logic        ln;
        logic [15:0] v0, v1;
        int          s0, s1, cur, b0, b1, d0, d1, o1;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    initial begin
        logic [5:0]  rops;
        logic [15:0] rlv;
        int          r;

        vecs = '{
            '{OP_LOAD, 16'h0999, 1'b0, 16'h0999, 16'h0999, 0, 0, 0, 0, 0, 0, 0, 0},
            '{OP_INC,  16'h0000, 1'b0, 16'h0990, 16'h1000, 0, 0, 0, 0, 0, 1, 1, 0},
            '{OP_LOAD, 16'h9999, 1'b0, 16'h9999, 16'h9999, 0, 0, 0, 0, 0, 0, 0, 0},
            '{OP_INC,  16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 0, 0, 0, 1, 0, 1},
            '{OP_NONE, 16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 0, 0, 0, 1, 0, 0},
            '{OP_RIGHT,16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 4, 1, 0, 1, 0, 0},
            '{OP_LEFT, 16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 0, 0, 0, 1, 0, 0},
            '{OP_LEFT, 16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 1, 0, 0, 1, 0, 0},
            '{OP_LEFT, 16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 2, 0, 0, 1, 0, 0},
            '{OP_LEFT, 16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 3, 0, 0, 1, 0, 0},
            '{OP_LEFT, 16'h0000, 1'b0, 16'h9990, 16'h9999, 0, 0, 4, 1, 0, 1, 0, 0},
            '{OP_LOAD, 16'h0005, 1'b1, 16'h0005, 16'h0005, 1, 1, 0, 0, 0, 0, 0, 0},
            '{OP_RIGHT,16'h0000, 1'b0, 16'h0005, 16'h0005, 1, 1, 4, 1, 0, 0, 0, 0},
            '{OP_INC,  16'h0000, 1'b0, 16'h0005, 16'h0005, 0, 0, 4, 1, 0, 1, 1, 0},
            '{OP_LOAD, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1, 1, 0, 0, 0, 0, 0, 0},
            '{OP_DEC,  16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 0},
            '{OP_DEC,  16'h0000, 1'b0, 16'h0009, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 1},
            '{OP_LOAD | OP_INC | OP_LEFT, 16'h1234, 1'b0, 16'h1234, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0},
            '{OP_CLR | OP_LOAD | OP_RIGHT, 16'h5555, 1'b1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0},
            '{OP_INC,  16'h0000, 1'b0, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 1, 1, 0},
            '{OP_RIGHT,16'h0000, 1'b0, 16'h0001, 16'h0001, 0, 0, 4, 1, 0, 1, 1, 0},
            '{OP_RIGHT,16'h0000, 1'b0, 16'h0001, 16'h0001, 0, 0, 3, 1, 0, 1, 1, 0},
            '{OP_DEC,  16'h0000, 1'b0, 16'h9001, 16'h0001, 0, 0, 3, 1, 0, 1, 1, 1},
            '{OP_INC,  16'h0000, 1'b0, 16'h0001, 16'h1001, 0, 0, 3, 1, 0, 1, 1, 0},
            '{OP_RIGHT,16'h0000, 1'b0, 16'h0001, 16'h1001, 0, 0, 2, 1, 0, 1, 1, 0},
            '{OP_RIGHT,16'h0000, 1'b0, 16'h0001, 16'h1001, 0, 0, 1, 1, 0, 1, 1, 0},
            '{OP_RIGHT,16'h0000, 1'b0, 16'h0001, 16'h1001, 0, 0, 0, 0, 0, 1, 1, 0},
            '{OP_DEC,  16'h0000, 1'b0, 16'h0000, 16'h1000, 0, 0, 0, 0, 0, 1, 1, 0}
        };

        cycle(OP_NONE, 16'h0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].ops, vecs[i].lv, vecs[i].ln, 1'b1);
            chk($sformatf("row%0d_value0", i), 32'(value0), 32'(vecs[i].v0));
            chk($sformatf("row%0d_value1", i), 32'(value1), 32'(vecs[i].v1));
            chk($sformatf("row%0d_sign0", i), 32'(sign0), vecs[i].s0);
            chk($sformatf("row%0d_sign1", i), 32'(sign1), vecs[i].s1);
            chk($sformatf("row%0d_curr0", i), 32'(curr0), vecs[i].cur);
            chk($sformatf("row%0d_curr1", i), 32'(curr1), vecs[i].cur);
            chk($sformatf("row%0d_base0", i), 32'(base0), vecs[i].b0);
            chk($sformatf("row%0d_base1", i), 32'(base1), vecs[i].b1);
            chk($sformatf("row%0d_dirty0", i), 32'(dirty0), vecs[i].d0);
            chk($sformatf("row%0d_dirty1", i), 32'(dirty1), vecs[i].d1);
            chk($sformatf("row%0d_ovf0", i), 32'(ovf0), 0);
            chk($sformatf("row%0d_ovf1", i), 32'(ovf1), vecs[i].o1);
        end

        // Reset with pulses active, then the idle blink cadence.
        cycle(OP_INC | OP_LEFT | OP_LOAD, 16'h1234, 1'b1, 1'b0);
        chk("rst_value0", 32'(value0), 32'h0);
        chk("rst_value1", 32'(value1), 32'h0);
        chk("rst_curr0", 32'(curr0), 32'h0);
        chk("rst_base1", 32'(base1), 32'h0);
        chk("rst_disp0", 32'(disp0), 32'h0);
        chk("rst_disp1", 32'(disp1), 32'h01F0_0000);
        for (int n = 1; n <= 4; n++) cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        chk("blink_vis_c4", 32'(disp0[4:0]), 32'd0);
        cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        chk("blink_hid_c5_0", 32'(disp0[4:0]), 32'd31);
        chk("blink_hid_c5_1", 32'(disp1[4:0]), 32'd31);
        for (int n = 6; n <= 8; n++) cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        chk("blink_hid_c8", 32'(disp0[4:0]), 32'd31);
        cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        chk("blink_vis_c9", 32'(disp0[4:0]), 32'd0);
        for (int n = 10; n <= 12; n++) cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        cycle(OP_LEFT, 16'h0, 1'b0, 1'b1);
        chk("left_hid_curr", 32'(curr0), 32'd1);
        chk("left_hid_old_slot", 32'(disp0[4:0]), 32'd31);
        cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        chk("left_hid_new_slot", 32'(disp0[9:5]), 32'd0);
        chk("left_hid_old_slot_back", 32'(disp0[4:0]), 32'd0);

        // Reset in the middle of a blink period.
        cycle(OP_INC, 16'h0, 1'b0, 1'b1);
        chk("pre_rst_value0", 32'(value0), 32'h0010);
        cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        cycle(OP_INC, 16'h0, 1'b0, 1'b0);
        chk("midrst_value0", 32'(value0), 32'h0);
        chk("midrst_dirty0", 32'(dirty0), 32'h0);
        chk("midrst_curr1", 32'(curr1), 32'h0);
        chk("midrst_disp1", 32'(disp1), 32'h01F0_0000);
        for (int n = 1; n <= 5; n++) cycle(OP_NONE, 16'h0, 1'b0, 1'b1);
        chk("midrst_blink_c5", 32'(disp0[4:0]), 32'd31);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rops = OP_NONE;
            if ($urandom_range(0, 99) < 2)  rops |= OP_CLR;
            if ($urandom_range(0, 99) < 6)  rops |= OP_LOAD;
            if ($urandom_range(0, 99) < 15) rops |= OP_LEFT;
            if ($urandom_range(0, 99) < 15) rops |= OP_RIGHT;
            if ($urandom_range(0, 99) < 25) rops |= OP_INC;
            if ($urandom_range(0, 99) < 25) rops |= OP_DEC;
            rlv = '0;
            r = $urandom_range(0, 9);
            if (r == 0)      rlv = 16'h9999;
            else if (r != 1) for (int j = 0; j < 4; j++) rlv[4*j +: 4] = 4'($urandom_range(0, 9));
            cycle(rops, rlv, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
